// File: rtl/wb_trace_buffer.sv
// Writeback trace FIFO: logs {reg, data, cycle tag} per register-file write; entries visible 1 cycle after capture.
// Drained over trace_valid/trace_ready; a full FIFO without a same-edge pop drops the write and counts it.
module wb_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_en,
  input  logic [4:0]       wb_reg,
  input  logic [31:0]      wb_data,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [4:0]       trace_reg,
  output logic [31:0]      trace_data,
  output logic [CNT_W-1:0] trace_cycle,
  input  logic             clear,
  output logic             overflow,
  output logic [7:0]       drop_cnt,
  input  logic             watch_en,
  input  logic [4:0]       watch_reg,
  input  logic [31:0]      watch_data,
  output logic             watch_hit
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef struct packed {
    logic [4:0]       rg;
    logic [31:0]      dat;
    logic [CNT_W-1:0] cyc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head_q, head_d, new_entry;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;
  logic             hit_q, hit_d;
  logic             push_req, full, pop, push_ok, drop;

  always_comb begin
    push_req  = wb_en && (wb_reg != 5'd0);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = vld_q && trace_ready;
    new_entry = '{rg: wb_reg, dat: wb_data, cyc: cnt_q};
    push_ok   = push_req && (!full || pop) && !clear;
    drop      = push_req && full && !pop && !clear;

    cnt_d    = cnt_q + CNT_W'(1);
    hit_d    = watch_en && push_req && (wb_reg == watch_reg) && (wb_data == watch_data);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    head_d   = head_q;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      drop_d   = 8'd0;
      head_d   = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
      // The new head is the incoming write only when it lands in the slot the read pointer moves to.
      if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) head_d = new_entry;
      else                                                   head_d = mem_q[rd_ptr_d[AW-1:0]];
    end

    vld_d = (wr_ptr_d != rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= 1'b0;
      head_q   <= '0;
      cnt_q    <= CNT_W'(1);
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
      hit_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      head_q   <= head_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      hit_q    <= hit_d;
    end
  end

  assign trace_valid = vld_q;
  assign trace_reg   = head_q.rg;
  assign trace_data  = head_q.dat;
  assign trace_cycle = head_q.cyc;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_q;
  assign watch_hit   = hit_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: capture, drop/overflow, clear, full-with-pop, watchpoint, async reset.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        trace_valid;
  logic        trace_ready;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;
  logic [31:0] trace_cycle;
  logic        clear;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        watch_en;
  logic [4:0]  watch_reg;
  logic [31:0] watch_data;
  logic        watch_hit;

  int checks = 0;
  int failures = 0;

  wb_trace_buffer #(.DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_reg(trace_reg), .trace_data(trace_data), .trace_cycle(trace_cycle),
    .clear(clear), .overflow(overflow), .drop_cnt(drop_cnt),
    .watch_en(watch_en), .watch_reg(watch_reg), .watch_data(watch_data),
    .watch_hit(watch_hit)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wb_en = 0; wb_reg = 0; wb_data = 0; trace_ready = 0; clear = 0;
    watch_en = 0; watch_reg = 0; watch_data = 0;
    tick(); tick();
    checks++;
    if (trace_valid !== 1'b0 || trace_reg !== 5'd0 || trace_data !== 32'd0 || trace_cycle !== 32'd0) begin
      failures++;
      $display("FAIL reset_head: valid=%0b reg=%0d data=%0d cycle=%0d required all 0",
               trace_valid, trace_reg, trace_data, trace_cycle);
    end
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0 || watch_hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: overflow=%0b drop_cnt=%0d watch_hit=%0b required 0/0/0",
               overflow, drop_cnt, watch_hit);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    repeat (11) tick();
    trace_ready = 1'b0;
    push(5'd15, 32'd4);
    checks++;
    if (trace_valid !== 1'b1 || trace_reg !== 5'd15 || trace_data !== 32'd4 || trace_cycle !== 32'd12) begin
      failures++;
      $display("FAIL capture_first: valid=%0b reg=%0d data=%0d cycle=%0d required 1/15/4/12",
               trace_valid, trace_reg, trace_data, trace_cycle);
    end
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    checks++;
    if (trace_valid !== 1'b0) begin
      failures++;
      $display("FAIL pop_to_empty: valid=%0b required 0", trace_valid);
    end
  endtask

  task automatic test_zero_reg();
    watch_en = 1'b1; watch_reg = 5'd0; watch_data = 32'd99;
    push(5'd0, 32'd99);
    checks++;
    if (trace_valid !== 1'b0 || drop_cnt !== 8'd0 || watch_hit !== 1'b0) begin
      failures++;
      $display("FAIL zero_reg: valid=%0b drop_cnt=%0d watch_hit=%0b required 0/0/0",
               trace_valid, drop_cnt, watch_hit);
    end
    watch_en = 1'b0;
  endtask

  task automatic test_overflow_clear();
    trace_ready = 1'b0;
    for (int i = 1; i <= 10; i++) push(5'(i), 32'(i * 10));
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      failures++;
      $display("FAIL overflow_count: overflow=%0b drop_cnt=%0d required 1/2", overflow, drop_cnt);
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_reg !== 5'(k) || trace_data !== 32'(k * 10)) begin
        failures++;
        $display("FAIL drain_%0d: valid=%0b reg=%0d data=%0d required 1/%0d/%0d",
                 k, trace_valid, trace_reg, trace_data, k, k * 10);
      end
      trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    end
    checks++;
    if (trace_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: valid=%0b required 0", trace_valid);
    end
    push(5'd20, 32'd5);
    checks++;
    if (trace_valid !== 1'b1 || trace_reg !== 5'd20) begin
      failures++;
      $display("FAIL pre_clear: valid=%0b reg=%0d required 1/20", trace_valid, trace_reg);
    end
    clear = 1'b1; trace_ready = 1'b1;
    push(5'd21, 32'd6);
    clear = 1'b0; trace_ready = 1'b0;
    checks++;
    if (trace_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clear: valid=%0b overflow=%0b drop_cnt=%0d required 0/0/0",
               trace_valid, overflow, drop_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    trace_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(5'(i), 32'(i * 10));
    trace_ready = 1'b1;
    push(5'd9, 32'd90);
    trace_ready = 1'b0;
    checks++;
    if (trace_valid !== 1'b1 || trace_reg !== 5'd2 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_push_pop: valid=%0b reg=%0d drop_cnt=%0d overflow=%0b required 1/2/0/0",
               trace_valid, trace_reg, drop_cnt, overflow);
    end
    for (int k = 2; k <= 9; k++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_reg !== 5'(k) || trace_data !== 32'(k * 10)) begin
        failures++;
        $display("FAIL full_drain_%0d: valid=%0b reg=%0d data=%0d required 1/%0d/%0d",
                 k, trace_valid, trace_reg, trace_data, k, k * 10);
      end
      trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    end
    checks++;
    if (trace_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_drain_empty: valid=%0b required 0", trace_valid);
    end
  endtask

  task automatic test_back_to_back_watch();
    watch_en = 1'b1; watch_reg = 5'd8; watch_data = 32'd70;
    trace_ready = 1'b1;
    push(5'd8, 32'd70);
    checks++;
    if (watch_hit !== 1'b1 || trace_valid !== 1'b1 || trace_data !== 32'd70) begin
      failures++;
      $display("FAIL watch_match: hit=%0b valid=%0b data=%0d required 1/1/70",
               watch_hit, trace_valid, trace_data);
    end
    push(5'd8, 32'd71);
    checks++;
    if (watch_hit !== 1'b0 || trace_valid !== 1'b1 || trace_data !== 32'd71) begin
      failures++;
      $display("FAIL watch_nomatch: hit=%0b valid=%0b data=%0d required 0/1/71",
               watch_hit, trace_valid, trace_data);
    end
    tick();
    checks++;
    if (watch_hit !== 1'b0 || trace_valid !== 1'b0) begin
      failures++;
      $display("FAIL watch_idle: hit=%0b valid=%0b required 0/0", watch_hit, trace_valid);
    end
    trace_ready = 1'b0; watch_en = 1'b0;
  endtask

  task automatic test_async_reset();
    push(5'd3, 32'd30);
    push(5'd4, 32'd40);
    push(5'd5, 32'd50);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (trace_valid !== 1'b0 || drop_cnt !== 8'd0 || trace_reg !== 5'd0 || trace_cycle !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: valid=%0b drop_cnt=%0d reg=%0d cycle=%0d required 0/0/0/0",
               trace_valid, drop_cnt, trace_reg, trace_cycle);
    end
    tick();
    rst_n = 1'b1;
    push(5'd7, 32'd77);
    checks++;
    if (trace_valid !== 1'b1 || trace_reg !== 5'd7 || trace_data !== 32'd77 || trace_cycle !== 32'd1) begin
      failures++;
      $display("FAIL restart_cycle: valid=%0b reg=%0d data=%0d cycle=%0d required 1/7/77/1",
               trace_valid, trace_reg, trace_data, trace_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_zero_reg();
    test_overflow_clear();
    test_full_push_pop();
    test_back_to_back_watch();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
